// File: rtl/up_down_counter_sequencer.sv
// Command-driven sequencer that steers an up/down counter between programmable bounds,
// either as a single lo->hi sweep or as a counted (or endless) lo->hi->lo bounce.
module up_down_counter_sequencer #(
    parameter int WIDTH  = 4,
    parameter int LOOP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_mode,
    input  logic [WIDTH-1:0]  cmd_lo,
    input  logic [WIDTH-1:0]  cmd_hi,
    input  logic [LOOP_W-1:0] cmd_loops,
    input  logic              abort,
    output logic [WIDTH-1:0]  count,
    output logic              up_down,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              err,
    output logic [LOOP_W-1:0] loops_done,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2
    } state_t;

    // Handshake: a command transfers on any rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready is high exactly while IDLE, so commands
    // presented during a run are simply not taken and leave no trace.

    state_t              r_state;
    logic [WIDTH-1:0]    r_count;
    logic                r_up_down;
    logic [LOOP_W-1:0]   r_loops_done;
    logic                r_done;
    logic                r_aborted;
    logic                r_err;
    logic                r_mode;
    logic [WIDTH-1:0]    r_lo;
    logic [WIDTH-1:0]    r_hi;
    logic [LOOP_W-1:0]   r_loops;

    state_t              w_state;
    logic [WIDTH-1:0]    w_count;
    logic                w_up_down;
    logic [LOOP_W-1:0]   w_loops_done;
    logic                w_done;
    logic                w_aborted;
    logic                w_err;
    logic                w_mode;
    logic [WIDTH-1:0]    w_lo;
    logic [WIDTH-1:0]    w_hi;
    logic [LOOP_W-1:0]   w_loops;
    logic [LOOP_W-1:0]   w_loops_inc;

    assign w_loops_inc = r_loops_done + 1'b1;

    always_comb begin
        w_state      = r_state;
        w_count      = r_count;
        w_up_down    = r_up_down;
        w_loops_done = r_loops_done;
        w_done       = 1'b0;
        w_aborted    = 1'b0;
        w_err        = 1'b0;
        w_mode       = r_mode;
        w_lo         = r_lo;
        w_hi         = r_hi;
        w_loops      = r_loops;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_lo > cmd_hi) begin
                        w_err = 1'b1;
                    end else begin
                        w_mode       = cmd_mode;
                        w_lo         = cmd_lo;
                        w_hi         = cmd_hi;
                        w_loops      = cmd_loops;
                        w_count      = cmd_lo;
                        w_up_down    = 1'b1;
                        w_loops_done = '0;
                        w_state      = RUN_UP;
                    end
                end
            end
            RUN_UP: begin
                if (abort) begin
                    w_state   = IDLE;
                    w_aborted = 1'b1;
                end else if (r_count < r_hi) begin
                    w_count = r_count + 1'b1;
                end else if (!r_mode) begin
                    w_state = IDLE;
                    w_done  = 1'b1;
                end else begin
                    // Turnaround cycle: count holds at hi while direction flips.
                    w_state   = RUN_DOWN;
                    w_up_down = 1'b0;
                end
            end
            RUN_DOWN: begin
                if (abort) begin
                    w_state   = IDLE;
                    w_aborted = 1'b1;
                end else if (r_count > r_lo) begin
                    w_count = r_count - 1'b1;
                end else begin
                    w_loops_done = w_loops_inc;
                    if ((r_loops != '0) && (w_loops_inc == r_loops)) begin
                        w_state = IDLE;
                        w_done  = 1'b1;
                    end else begin
                        w_state   = RUN_UP;
                        w_up_down = 1'b1;
                    end
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_up_down    <= 1'b1;
            r_loops_done <= '0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_err        <= 1'b0;
            r_mode       <= 1'b0;
            r_lo         <= '0;
            r_hi         <= '0;
            r_loops      <= '0;
        end else begin
            r_state      <= w_state;
            r_count      <= w_count;
            r_up_down    <= w_up_down;
            r_loops_done <= w_loops_done;
            r_done       <= w_done;
            r_aborted    <= w_aborted;
            r_err        <= w_err;
            r_mode       <= w_mode;
            r_lo         <= w_lo;
            r_hi         <= w_hi;
            r_loops      <= w_loops;
        end
    end

    assign cmd_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign count      = r_count;
    assign up_down    = r_up_down;
    assign done       = r_done;
    assign aborted    = r_aborted;
    assign err        = r_err;
    assign loops_done = r_loops_done;
    assign dbg_state  = r_state;

endmodule
